// File: rtl/myencoder_pkg.sv
// myencoder_pkg: shared widths, pointer reset value and priority-select functions for myencoder.
package myencoder_pkg;
    localparam int REQ_W = 8;
    localparam int IDX_W = 3;
    localparam logic [IDX_W-1:0] RR_RESET = 3'd7;

    // Fixed priority: the highest set index wins.
    function automatic logic [IDX_W-1:0] pick_hi(input logic [REQ_W-1:0] req);
        pick_hi = '0;
        for (int i = 0; i < REQ_W; i++)
            if (req[i]) pick_hi = IDX_W'(i);
    endfunction

    // Rotating priority: last+1 is highest, then ascending with wrap.
    function automatic logic [IDX_W-1:0] pick_rr(input logic [REQ_W-1:0] req, input logic [IDX_W-1:0] last);
        pick_rr = '0;
        for (int k = REQ_W; k >= 1; k--)
            if (req[IDX_W'(int'(last) + k)]) pick_rr = IDX_W'(int'(last) + k);
    endfunction
endpackage

// File: rtl/myencoder_if.sv
// myencoder_if: request inputs and granted-index handshake of myencoder.
interface myencoder_if;
    import myencoder_pkg::*;
    logic [REQ_W-1:0] in_val;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_val;
    logic [REQ_W-1:0] pending;
    logic             overflow;
    modport master (output in_val, out_ready, input out_valid, out_val, pending, overflow);
    modport slave  (input in_val, out_ready, output out_valid, out_val, pending, overflow);
endinterface

// File: rtl/myencoder_sync.sv
// myencoder_sync: per-bit synchronizer chain followed by a registered rising-edge pulse.
module myencoder_sync
    import myencoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [REQ_W-1:0] din,
    output logic [REQ_W-1:0] rise
);
    logic [SYNC_STAGES-1:0][REQ_W-1:0] chain;
    logic [REQ_W-1:0]                  prv;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            chain <= '0;
            prv   <= '0;
            rise  <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prv   <= chain[SYNC_STAGES-1];
            rise  <= chain[SYNC_STAGES-1] & ~prv;
        end
    end
endmodule

// File: rtl/myencoder.sv
// myencoder: edge-triggered request latch with priority encoder and valid/ready output slot.
// Define MYENCODER_ROUND_ROBIN_EN for rotating priority; fixed highest-index priority otherwise.
module myencoder
    import myencoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input logic        sys_clk,
    input logic        sys_rst_n,
    myencoder_if.slave bus
);
    logic [REQ_W-1:0] edges, pend, clr;
    logic [IDX_W-1:0] sel, idx;
    logic             vld, ovf, load, take;

    myencoder_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .din      (bus.in_val),
        .rise     (edges)
    );

`ifdef MYENCODER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) ptr <= RR_RESET;
        else if (take)  ptr <= sel;
    end
    assign sel = pick_rr(pend, ptr);
`else
    assign sel = pick_hi(pend);
`endif

    assign load = ~vld | bus.out_ready;
    assign take = load & |pend;
    assign clr  = take ? REQ_W'(1) << sel : '0;

    // Same-cycle edges are OR-ed after the grant clear, so a set always beats a clear.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend <= '0;
            ovf  <= 1'b0;
            vld  <= 1'b0;
            idx  <= '0;
        end else begin
            pend <= (pend & ~clr) | edges;
            ovf  <= |(edges & pend & ~clr);
            if (load) vld <= take;
            if (take) idx <= sel;
        end
    end

    assign bus.out_valid = vld;
    assign bus.out_val   = idx;
    assign bus.pending   = pend;
    assign bus.overflow  = ovf;
endmodule

// File: doc/myencoder.md
MYENCODER -- requirements
Module: myencoder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, depth of the input synchronizer chain on in_val; legal range 2..4.
REQ-002 sys_clk  input  1  single rising-edge clock for all state.
REQ-003 sys_rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 in_val  input  8  request lines, asynchronous to sys_clk (keys, strobes); bit i requests index i.
REQ-005 out_ready  input  1  consumer accepts out_val when high with out_valid.
REQ-006 out_valid  output  1  out_val holds a granted index.
REQ-007 out_val  output  3  binary index of granted request.
REQ-008 pending  output  8  latched, not-yet-granted requests.
REQ-009 overflow  output  1  one-cycle pulse: request edge lost.

Function
REQ-010 Each in_val bit SHALL pass through SYNC_STAGES flops, then a one-flop rising-edge detector; only 0->1 transitions generate requests, so level-held inputs request once.
REQ-011 A detected edge on bit i SHALL set pending[i] on the next sys_clk edge.
REQ-012 Output slot loads when out_valid=0 or (out_valid & out_ready): if pending (excluding same-cycle edge sets) is nonzero, out_val=selected index, out_valid=1, selected pending bit cleared; else out_valid=0.
REQ-013 Fixed priority (default): highest set index wins (bit 7 highest), matching mydecoder index numbering so out_val fed to mydecoder reproduces the one-hot bit.
REQ-014 Latency: in_val rise sampled at edge k -> pending set at edge k+SYNC_STAGES+1 -> out_valid at edge k+SYNC_STAGES+2 if slot free.
REQ-015 out_val and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-016 Edge on bit i in the cycle pending[i] is being cleared by a grant: pending[i] stays set (set wins), no overflow.
REQ-017 Edge on bit i while pending[i]=1 and not being granted: pending unchanged, overflow pulses high for exactly one cycle.
REQ-018 Multiple simultaneous edges SHALL all set their pending bits in the same cycle; grants then occur one per accepted transfer.
REQ-019 Back-to-back: with out_ready held high and k pending bits, out_valid SHALL stay high for k consecutive cycles, one index per cycle.

Reset
REQ-020 While sys_rst_n=0: out_valid=0, out_val=0, pending=0, overflow=0, synchronizer and edge flops=0, round-robin pointer=7.
REQ-021 Reset mid-transfer SHALL discard all pending and in-flight grants; after release, inputs already high SHALL generate a request (edge from reset value 0).

Configuration
REQ-022 Macro MYENCODER_ROUND_ROBIN_EN: defined -> rotating priority; index (last_grant+1) mod 8 highest, ascending with wrap 7->0, pointer updates on every grant.
REQ-023 Undefined -> fixed priority per REQ-013, no pointer register; all other behaviour identical.

Structure
REQ-024 Shared package myencoder_pkg SHALL hold REQ_W=8, IDX_W=3, reset pointer value, and the priority-select function.
REQ-025 One sub-module, myencoder_sync, SHALL implement the per-bit synchronizer plus edge detector, instantiated once for 8 bits.

Verification
REQ-026 Reset, in_val=8'h00 held -> out_valid=0, pending=0, overflow=0 indefinitely.
REQ-027 in_val 8'h00->8'h24 (bits 2,5), out_ready=1, fixed priority -> out_val=5 then 2 on consecutive cycles, pending 8'h24->8'h04->8'h00.
REQ-028 out_ready=0, edges on bits 1,3 -> out_val=3 held stable with out_valid=1; then out_ready=1 -> 3 accepted, then 1.
REQ-029 Bit 4 pulsed twice while pending[4]=1 and out_ready=0 -> overflow single-cycle pulse, single grant of 4.
REQ-030 MYENCODER_ROUND_ROBIN_EN, bits 0,7 re-pulsed after every grant -> grants alternate 0,7,0,7 starting at 0 after reset.
REQ-031 sys_rst_n pulsed low with pending=8'hF0, out_valid=1 -> all outputs 0 asynchronously; after release with in_val=8'h01 held -> one grant of 0 only.
